// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Purpose  : Serial bit-pattern transmitter. Latches a parallel pattern of up
//            to MAX_LEN bits and shifts it out MSB-first, one bit per clock.
//            Supports a repeat count and an idle gap between frames.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - transfer request, honoured only in IDLE
//            pattern         - bits to send, active bits pattern[pat_len-1:0]
//            pat_len         - bits per frame (clamped to MAX_LEN, 0 = none)
//            rep             - frames to send (0 behaves as 1)
//            gap             - idle cycles between consecutive frames
//            seqOut/seqValid - serial data and its qualifier
//            frameStart      - first bit of each frame
//            busy            - high while shifting or in an inter-frame gap
//            done            - one-cycle pulse after the final bit
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int REP_W   = 4,
   parameter int GAP_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic [REP_W-1:0]   rep,
   input  logic [GAP_W-1:0]   gap,
   output logic               seqOut,
   output logic               seqValid,
   output logic               frameStart,
   output logic               busy,
   output logic               done
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [IDX_W-1:0]   bit_q, bit_d;       // index of the bit on the wire
   logic [REP_W-1:0]   frames_q, frames_d; // frames left, including current
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [GAP_W-1:0]   gcnt_q, gcnt_d;     // gap cycles left, including current

   logic seqOut_q, seqOut_d;
   logic seqValid_q, seqValid_d;
   logic frameStart_q, frameStart_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic [LEN_W-1:0] w_len_clamp;
   logic [IDX_W-1:0] w_first_idx_in;
   logic [IDX_W-1:0] w_first_idx_q;

   assign w_len_clamp    = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
   // Only meaningful for a non-zero length; then len-1 always fits in IDX_W.
   assign w_first_idx_in = IDX_W'(w_len_clamp - LEN_W'(1));
   assign w_first_idx_q  = IDX_W'(len_q - LEN_W'(1));

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pat_q        <= '0;
         len_q        <= '0;
         bit_q        <= '0;
         frames_q     <= '0;
         gap_q        <= '0;
         gcnt_q       <= '0;
         seqOut_q     <= 1'b0;
         seqValid_q   <= 1'b0;
         frameStart_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pat_q        <= pat_d;
         len_q        <= len_d;
         bit_q        <= bit_d;
         frames_q     <= frames_d;
         gap_q        <= gap_d;
         gcnt_q       <= gcnt_d;
         seqOut_q     <= seqOut_d;
         seqValid_q   <= seqValid_d;
         frameStart_q <= frameStart_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      len_d    = len_q;
      bit_d    = bit_q;
      frames_d = frames_q;
      gap_d    = gap_q;
      gcnt_d   = gcnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pat_d    = pattern;
               len_d    = w_len_clamp;
               frames_d = (rep == '0) ? REP_W'(1) : rep;
               gap_d    = gap;
               bit_d    = w_first_idx_in;
               state_d  = (w_len_clamp == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bit_q != '0) begin
               bit_d = bit_q - IDX_W'(1);
            end else if (frames_q > REP_W'(1)) begin
               frames_d = frames_q - REP_W'(1);
               if (gap_q != '0) begin
                  state_d = S_GAP;
                  gcnt_d  = gap_q;
               end else begin
                  // Back-to-back frame: restart at the MSB without a bubble.
                  bit_d = w_first_idx_q;
               end
            end else begin
               state_d = S_DONE;
            end
         end
         S_GAP: begin
            if (gcnt_q == GAP_W'(1)) begin
               state_d = S_SHIFT;
               bit_d   = w_first_idx_q;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------- outputs
   // Outputs are decoded from the next state so that they can be registered
   // and still line up with the cycle the state is entered.
   always_comb begin
      seqValid_d   = (state_d == S_SHIFT);
      seqOut_d     = seqValid_d & pat_d[bit_d];
      // The MSB index is only ever loaded at the start of a frame.
      frameStart_d = seqValid_d && (bit_d == IDX_W'(len_d - LEN_W'(1)));
      busy_d       = (state_d == S_SHIFT) || (state_d == S_GAP);
      done_d       = (state_d == S_DONE);
   end

   assign seqOut     = seqOut_q;
   assign seqValid   = seqValid_q;
   assign frameStart = frameStart_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Purpose  : Self-checking bench for seq_pattern_tx. A table of transfers is
//            expanded into per-cycle expected outputs on a scoreboard queue,
//            which is popped and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int REP_W   = 4;
   localparam int GAP_W   = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   pat_len;
   logic [REP_W-1:0]   rep;
   logic [GAP_W-1:0]   gap;
   logic               seqOut, seqValid, frameStart, busy, done;

   seq_pattern_tx #(
      .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_W(GAP_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern),
      .pat_len(pat_len), .rep(rep), .gap(gap),
      .seqOut(seqOut), .seqValid(seqValid), .frameStart(frameStart),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // {seqOut, seqValid, frameStart, busy, done}
   typedef struct packed {
      logic so; logic sv; logic fs; logic bz; logic dn;
   } obs_t;

   typedef struct {
      logic [7:0] pat;
      logic [3:0] len;
      logic [3:0] rep;
      logic [3:0] gap;
      int         cycles; // start edge to done pulse, hand-derived
   } vec_t;

   obs_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input obs_t exp, input string name, input int cyc);
      obs_t act;
      act = obs_t'({seqOut, seqValid, frameStart, busy, done});
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: so/sv/fs/busy/done got %b required %b",
                  name, cyc, act, exp);
      end
   endtask

   // Expected cycle-by-cycle outputs following the start edge.
   task automatic build(input logic [7:0] p, input logic [3:0] l,
                        input logic [3:0] r, input logic [3:0] g);
      int len, reps;
      len  = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
      reps = (r == 4'd0) ? 1 : int'(r);
      if (len != 0) begin
         for (int f = 0; f < reps; f++) begin
            for (int b = len - 1; b >= 0; b--)
               sb.push_back(obs_t'({p[b], 1'b1, (b == len - 1), 1'b1, 1'b0}));
            if (f < reps - 1)
               for (int k = 0; k < int'(g); k++)
                  sb.push_back(obs_t'(5'b00010));
         end
      end
      sb.push_back(obs_t'(5'b00001));
      sb.push_back(obs_t'(5'b00000));
   endtask

   // Runs one transfer. If intr_at >= 0, a conflicting start (with different
   // fields) is raised after cycle intr_at+1 and held through the done cycle.
   task automatic run_vec(input vec_t v, input int intr_at, input string name);
      int n, done_at;
      obs_t e;
      sb.delete();
      build(v.pat, v.len, v.rep, v.gap);
      pattern = v.pat; pat_len = v.len; rep = v.rep; gap = v.gap;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = sb.size();
      done_at = -1;
      for (int i = 0; i < n; i++) begin
         e = sb.pop_front();
         if (done === 1'b1 && done_at < 0) done_at = i + 1;
         check(e, name, i + 1);
         if (intr_at >= 0 && i == intr_at) begin
            start = 1'b1; pattern = ~v.pat; pat_len = 4'd5; rep = 4'd7; gap = 4'd1;
         end
         if (i == n - 1) start = 1'b0;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (done_at != v.cycles) begin
         n_bad++;
         $display("FAIL %s latency: done at cycle %0d required %0d", name, done_at, v.cycles);
      end
      check(obs_t'(5'b00000), {name, "_idle"}, n + 1);
   endtask

   vec_t vecs[9];

   initial begin
      obs_t e;
      vec_t v1;
      vecs[0] = '{8'h0C, 4'd4,  4'd1, 4'd0, 5};   // 1,1,0,0
      vecs[1] = '{8'h0D, 4'd4,  4'd2, 4'd2, 11};  // 1101 gap 1101
      vecs[2] = '{8'h06, 4'd3,  4'd3, 4'd0, 10};  // 110110110
      vecs[3] = '{8'h06, 4'd3,  4'd0, 4'd0, 4};   // rep 0 -> one frame
      vecs[4] = '{8'hA5, 4'd0,  4'd1, 4'd0, 1};   // zero length
      vecs[5] = '{8'hA5, 4'd15, 4'd1, 4'd0, 9};   // clamped to 8 bits
      vecs[6] = '{8'h96, 4'd8,  4'd2, 4'd1, 18};
      vecs[7] = '{8'h02, 4'd2,  4'd1, 4'd3, 3};   // gap unused on one frame
      vecs[8] = '{8'hFF, 4'd1,  4'd3, 4'd1, 6};

      rst = 1'b1; start = 1'b0; pattern = '0; pat_len = '0; rep = '0; gap = '0;
      repeat (3) @(posedge clk);
      #1;
      check(obs_t'(5'b00000), "reset", 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check(obs_t'(5'b00000), "idle_after_reset", 0);

      for (int i = 0; i < 9; i++)
         run_vec(vecs[i], -1, $sformatf("vec%0d", i));

      // Conflicting start while busy and while in DONE must be ignored.
      run_vec(vecs[1], 1, "start_ignored");

      // Reset during cycle 3 of the first transfer abandons it silently.
      v1 = vecs[0];
      sb.delete();
      build(v1.pat, v1.len, v1.rep, v1.gap);
      pattern = v1.pat; pat_len = v1.len; rep = v1.rep; gap = v1.gap;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e = sb.pop_front();
         check(e, "pre_reset", i + 1);
         if (i == 2) rst = 1'b1;
         @(posedge clk); #1;
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check(obs_t'(5'b00000), "after_reset", 4 + i);
         @(posedge clk); #1;
      end
      run_vec(vecs[0], -1, "restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard bound in case the sequencing above ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
